// File: rtl/debounce_bank.sv
// -----------------------------------------------------------------------------
// debounce_bank
//
// Multi-channel switch debouncer for push-buttons and slide switches. Every
// channel is fully independent and has its own state machine, debounce
// counter and hold counter. Each channel reports a registered debounced level,
// one-cycle rise/fall ticks and a one-cycle long-press (hold) tick.
//
// Parameters:
//   WIDTH       - number of independent channels
//   DB_CYCLES   - clocks the sample must stay stable before the level flips
//                 (legal range >= 1)
//   HOLD_CYCLES - debounced-high clocks before hold_tick fires; 0 removes the
//                 hold counter and ties hold_tick low
//
// Optional feature (compile-time macro):
//   DEBOUNCE_BANK_SYNC_EN - when defined, every sw bit goes through a 2-flop
//                           synchroniser (reset to 0) before its state
//                           machine, which adds 2 clocks to every latency.
//                           When undefined, sw must already be synchronous
//                           to clk.
//
// Ports:
//   clk        in   1        system clock, all logic on the rising edge
//   reset_n    in   1        synchronous active-low reset
//   sw         in   WIDTH    raw switch inputs, one bit per channel
//   db_level   out  WIDTH    registered debounced level per channel
//   rise_tick  out  WIDTH    one-cycle pulse on each debounced 0->1
//   fall_tick  out  WIDTH    one-cycle pulse on each debounced 1->0
//   hold_tick  out  WIDTH    one-cycle pulse, at most once per press
//   dbg_state  out  2*WIDTH  per-channel FSM state, channel i in bits
//                            [2*i+1:2*i] (ZERO=0, WAIT1=1, ONE=2, WAIT0=3)
// -----------------------------------------------------------------------------
module debounce_bank #(
   parameter int WIDTH       = 4,
   parameter int DB_CYCLES   = 2_000_000,
   parameter int HOLD_CYCLES = 50_000_000
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic [WIDTH-1:0]     sw,
   output logic [WIDTH-1:0]     db_level,
   output logic [WIDTH-1:0]     rise_tick,
   output logic [WIDTH-1:0]     fall_tick,
   output logic [WIDTH-1:0]     hold_tick,
   output logic [2*WIDTH-1:0]   dbg_state
);

   typedef enum logic [1:0] {
      ZERO  = 2'd0,
      WAIT1 = 2'd1,
      ONE   = 2'd2,
      WAIT0 = 2'd3
   } state_t;

   // The debounce counter only ever has to reach DB_CYCLES-1.
   localparam int CNT_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   for (genvar i = 0; i < WIDTH; i++) begin : g_ch

      // ----------------------------------------------------------------
      // Sample selection
      // ----------------------------------------------------------------
      logic s;

`ifdef DEBOUNCE_BANK_SYNC_EN
      logic sync1_q;
      logic sync2_q;

      always_ff @(posedge clk) begin
         if (!reset_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
         end else begin
            sync1_q <= sw[i];
            sync2_q <= sync1_q;
         end
      end

      assign s = sync2_q;
`else
      assign s = sw[i];
`endif

      // ----------------------------------------------------------------
      // Debounce state machine
      // ----------------------------------------------------------------
      state_t           state_q, state_d;
      logic [CNT_W-1:0] cnt_q,   cnt_d;
      logic             lvl_q,   lvl_d;
      logic             rise_q,  rise_d;
      logic             fall_q,  fall_d;

      always_ff @(posedge clk) begin
         if (!reset_n) begin
            state_q <= ZERO;
            cnt_q   <= '0;
            lvl_q   <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
         end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            lvl_q   <= lvl_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
         end
      end

      // WAITx counts the stable samples seen after the one that left the
      // settled state; the transition completes on the sample that finds
      // cnt already at DB_CYCLES-1, i.e. after DB_CYCLES+1 stable samples.
      always_comb begin
         state_d = state_q;
         cnt_d   = cnt_q;
         lvl_d   = lvl_q;
         rise_d  = 1'b0;
         fall_d  = 1'b0;
         case (state_q)
            ZERO: begin
               if (s) begin
                  state_d = WAIT1;
                  cnt_d   = '0;
               end
            end
            WAIT1: begin
               if (!s) begin
                  state_d = ZERO;
                  cnt_d   = '0;
               end else if (cnt_q == CNT_LAST) begin
                  state_d = ONE;
                  cnt_d   = '0;
                  lvl_d   = 1'b1;
                  rise_d  = 1'b1;
               end else begin
                  cnt_d   = cnt_q + CNT_ONE;
               end
            end
            ONE: begin
               if (!s) begin
                  state_d = WAIT0;
                  cnt_d   = '0;
               end
            end
            WAIT0: begin
               if (s) begin
                  state_d = ONE;
                  cnt_d   = '0;
               end else if (cnt_q == CNT_LAST) begin
                  state_d = ZERO;
                  cnt_d   = '0;
                  lvl_d   = 1'b0;
                  fall_d  = 1'b1;
               end else begin
                  cnt_d   = cnt_q + CNT_ONE;
               end
            end
            default: begin
               state_d = ZERO;
               cnt_d   = '0;
               lvl_d   = 1'b0;
            end
         endcase
      end

      // ----------------------------------------------------------------
      // Hold (long-press) detection
      // ----------------------------------------------------------------
      if (HOLD_CYCLES > 0) begin : g_hold
         localparam int HCNT_W = $clog2(HOLD_CYCLES + 1);
         localparam logic [HCNT_W-1:0] HOLD_MAX  = HCNT_W'(HOLD_CYCLES);
         localparam logic [HCNT_W-1:0] HOLD_LAST = HCNT_W'(HOLD_CYCLES - 1);
         localparam logic [HCNT_W-1:0] HCNT_ONE  = HCNT_W'(1);

         logic [HCNT_W-1:0] hcnt_q, hcnt_d;
         logic              hold_q, hold_d;

         always_ff @(posedge clk) begin
            if (!reset_n) begin
               hcnt_q <= '0;
               hold_q <= 1'b0;
            end else begin
               hcnt_q <= hcnt_d;
               hold_q <= hold_d;
            end
         end

         // Counting follows the debounced level, so a bounce that only
         // visits WAIT0 keeps the count going. Saturation at HOLD_MAX
         // makes the tick fire only once per press; the clear on the
         // fall edge re-arms it and also keeps hold off the fall_tick
         // cycle.
         always_comb begin
            hcnt_d = hcnt_q;
            hold_d = 1'b0;
            if (fall_d) begin
               hcnt_d = '0;
            end else if (lvl_q && (hcnt_q != HOLD_MAX)) begin
               hcnt_d = hcnt_q + HCNT_ONE;
               hold_d = (hcnt_q == HOLD_LAST);
            end
         end

         assign hold_tick[i] = hold_q;
      end else begin : g_no_hold
         assign hold_tick[i] = 1'b0;
      end

      // ----------------------------------------------------------------
      // Output mapping
      // ----------------------------------------------------------------
      assign db_level[i]         = lvl_q;
      assign rise_tick[i]        = rise_q;
      assign fall_tick[i]        = fall_q;
      assign dbg_state[2*i +: 2] = state_q;

   end

endmodule
